// File: rtl/alu_issue_stage.sv
// alu_issue_stage: registered issue/result stage around alu_core with a 2-entry result FIFO.
// Latency: a request accepted at edge t is on out_* in cycle t+1 when the FIFO was empty.
// Backpressure: in_ready = (count != 2), from registered state only; out_* hold while out_valid && !out_ready.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   in_valid/in_ready                  request handshake from decode
//   in_op, in_a, in_b, in_tag          operation code, operands, destination tag
//   out_valid/out_ready                result handshake toward writeback
//   out_result, out_tag                head entry result and tag
//   out_zero, out_dbz                  head result is zero / head was a divide by zero
//   retired_cnt                        results consumed by writeback (wraps)

// Combinational ALU core; operands zero-extended to 2N.
// Latency: none (combinational).
// Backpressure: none.
module alu_core #(
  parameter int N = 8
) (
  input  logic [2:0]     op,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] result
);
  logic [2*N-1:0] ax;
  logic [2*N-1:0] bx;
  logic [2*N-1:0] b_div;

  assign ax = {{N{1'b0}}, a};
  assign bx = {{N{1'b0}}, b};
  // A zero divisor is replaced so the quotient never goes unknown; the
  // issue stage overrides that result anyway.
  assign b_div = (b == '0) ? {{(2*N-1){1'b0}}, 1'b1} : bx;

  always_comb begin
    result = '0;
    case (op)
      3'b000:  result = ax + bx;
      3'b001:  result = ax & bx;
      3'b010:  result = ax - bx;
      3'b011:  result = ax | bx;
      3'b100:  result = ax ^ bx;
      3'b101:  result = ax * bx;
      3'b110:  result = ax / b_div;
      default: result = (a < b) ? ax : bx;
    endcase
  end
endmodule

// Generic 2-entry FIFO with wrapping 1-bit pointers; storage resets to zero.
// Latency: a push is visible at the head one cycle later when empty.
// Backpressure: caller qualifies push with !full and pop with !empty.
module fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_vld,
  output logic [W-1:0] head_dat,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_vld) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_vld) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_vld, pop_vld})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];
endmodule

module alu_issue_stage #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic [3:0]       in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_result,
  output logic [3:0]       out_tag,
  output logic             out_zero,
  output logic             out_dbz,
  output logic [CNT_W-1:0] retired_cnt
);
  typedef struct packed {
    logic [2*N-1:0] result;
    logic [3:0]     tag;
    logic           zero;
    logic           dbz;
  } entry_t;

  logic [2*N-1:0] core_result;
  logic [1:0]     count;
  logic           accept;
  logic           pop;
  logic           dbz;
  entry_t         new_entry;
  entry_t         head;

  alu_core #(.N(N)) u_core (
    .op     (in_op),
    .a      (in_a),
    .b      (in_b),
    .result (core_result)
  );

  assign dbz = (in_op == 3'b110) && (in_b == '0);

  always_comb begin
    new_entry        = '0;
    new_entry.result = dbz ? '1 : core_result;
    new_entry.tag    = in_tag;
    // Zero flag is taken from the value actually stored, after the dbz override.
    new_entry.zero   = (new_entry.result == '0);
    new_entry.dbz    = dbz;
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  fifo2 #(.W($bits(entry_t))) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (accept),
    .push_dat (new_entry),
    .pop_vld  (pop),
    .head_dat (head),
    .count    (count)
  );

  assign out_result = head.result;
  assign out_tag    = head.tag;
  assign out_zero   = head.zero;
  assign out_dbz    = head.dbz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
    end else if (pop) begin
      retired_cnt <= retired_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed and random stimulus against a queue-based reference model.
// Latency: checks outputs on the falling edge after every rising edge.
// Backpressure: out_ready driven directed and random.
module tb_alu_issue_stage;
  localparam int N     = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [N-1:0]     in_a;
  logic [N-1:0]     in_b;
  logic [3:0]       in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-1:0]   out_result;
  logic [3:0]       out_tag;
  logic             out_zero;
  logic             out_dbz;
  logic [CNT_W-1:0] retired_cnt;

  alu_issue_stage #(.N(N), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_tag     (out_tag),
    .out_zero    (out_zero),
    .out_dbz     (out_dbz),
    .retired_cnt (retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res;
    int tag;
    bit dbz;
  } exp_t;

  exp_t q[$];
  int   retired_exp = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  // Reference arithmetic on plain integers, results reduced to 2N bits.
  function automatic int ref_res(input int op, input int a, input int b);
    int r;
    case (op)
      0:       r = a + b;
      1:       r = a & b;
      2:       r = a - b;
      3:       r = a | b;
      4:       r = a ^ b;
      5:       r = a * b;
      6:       r = (b == 0) ? 'hFFFF : a / b;
      default: r = (a < b) ? a : b;
    endcase
    return r & ((1 << (2 * N)) - 1);
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_out_valid"}, int'(out_valid), int'(q.size() != 0));
    check({tag, "_in_ready"}, int'(in_ready), int'(q.size() != 2));
    check({tag, "_retired"}, int'(retired_cnt), retired_exp);
    if (q.size() != 0) begin
      check({tag, "_result"}, int'(out_result), q[0].res);
      check({tag, "_tag"}, int'(out_tag), q[0].tag);
      check({tag, "_zero"}, int'(out_zero), int'(q[0].res == 0));
      check({tag, "_dbz"}, int'(out_dbz), int'(q[0].dbz));
    end
  endtask

  // Drive one cycle of inputs, advance the model at the rising edge, check at the falling edge.
  task automatic cycle(input bit iv, input int op, input int a, input int b,
                       input int tag, input bit ordy, input string name);
    bit   acc;
    bit   pp;
    exp_t e;
    in_valid  = iv;
    in_op     = 3'(op);
    in_a      = 8'(a);
    in_b      = 8'(b);
    in_tag    = 4'(tag);
    out_ready = ordy;
    @(posedge clk);
    acc = iv && (q.size() < 2);
    pp  = ordy && (q.size() > 0);
    if (pp) begin
      void'(q.pop_front());
      retired_exp = (retired_exp + 1) % (1 << CNT_W);
    end
    if (acc) begin
      e.res = ref_res(op, a, b);
      e.tag = tag;
      e.dbz = (op == 6) && (b == 0);
      q.push_back(e);
    end
    @(negedge clk);
    check_outputs(name);
  endtask

  initial begin
    int exp_tab[8] = '{207, 0, 193, 207, 207, 1400, 28, 7};

    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    in_tag = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_retired", int'(retired_cnt), 0);
    check("rst_result", int'(out_result), 0);
    check("rst_tag", int'(out_tag), 0);
    check("rst_zero", int'(out_zero), 0);
    check("rst_dbz", int'(out_dbz), 0);
    @(negedge clk);

    // One request per op, a=200 b=7, tag = op code, writeback always ready.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, i, 200, 7, i, 1'b1, "op");
      check("op_const_result", int'(out_result), exp_tab[i]);
      check("op_const_tag", int'(out_tag), i);
    end
    cycle(1'b0, 0, 0, 0, 0, 1'b1, "op_drain");

    // Divide by zero, then a zero result from sub.
    cycle(1'b1, 6, 9, 0, 3, 1'b0, "dbz");
    check("dbz_const_result", int'(out_result), 'hFFFF);
    check("dbz_const_flag", int'(out_dbz), 1);
    check("dbz_const_zero", int'(out_zero), 0);
    cycle(1'b1, 2, 5, 5, 4, 1'b1, "zero");
    check("zero_const_result", int'(out_result), 0);
    check("zero_const_flag", int'(out_zero), 1);
    check("zero_const_dbz", int'(out_dbz), 0);
    cycle(1'b0, 0, 0, 0, 0, 1'b1, "zero_drain");

    // Backpressure: third request refused while full, head held.
    cycle(1'b1, 0, 1, 2, 1, 1'b0, "bp1");
    cycle(1'b1, 0, 3, 4, 2, 1'b0, "bp2");
    check("bp_const_full", int'(in_ready), 0);
    cycle(1'b1, 0, 5, 6, 3, 1'b0, "bp3");
    check("bp_const_head_result", int'(out_result), 3);
    check("bp_const_head_tag", int'(out_tag), 1);
    cycle(1'b1, 0, 5, 6, 3, 1'b1, "bp_pop1");
    check("bp_const_second_tag", int'(out_tag), 2);
    cycle(1'b1, 0, 5, 6, 3, 1'b1, "bp_pop2");
    check("bp_const_third_tag", int'(out_tag), 3);
    check("bp_const_third_result", int'(out_result), 11);
    cycle(1'b0, 0, 0, 0, 0, 1'b1, "bp_drain");

    // Simultaneous accept and pop at count 1.
    cycle(1'b1, 5, 10, 10, 5, 1'b0, "sim1");
    cycle(1'b1, 7, 9, 4, 6, 1'b1, "sim2");
    check("sim_const_tag", int'(out_tag), 6);
    check("sim_const_result", int'(out_result), 4);
    cycle(1'b0, 0, 0, 0, 0, 1'b1, "sim_drain");

    // Asynchronous reset with two entries held.
    cycle(1'b1, 0, 1, 1, 1, 1'b0, "ar1");
    cycle(1'b1, 0, 2, 2, 2, 1'b0, "ar2");
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_in_ready", int'(in_ready), 1);
    check("arst_retired", int'(retired_cnt), 0);
    q.delete();
    retired_exp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs("arst_post");

    // 17 pops wrap a 4-bit counter to 1.
    for (int i = 0; i < 18; i++) begin
      cycle(1'b1, 0, i, 1, i % 16, 1'b1, "wrap");
    end
    check("wrap_const_retired", int'(retired_cnt), 1);
    cycle(1'b0, 0, 0, 0, 0, 1'b1, "wrap_drain");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      int op;
      int b;
      op = int'($urandom_range(0, 7));
      b  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
      cycle(1'($urandom_range(0, 1)), op, int'($urandom_range(0, 255)), b,
            int'($urandom_range(0, 15)), 1'($urandom_range(0, 2) != 0), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
